// File: rtl/alarm_pkg.sv
// Shared definitions for the vehicle anti-theft controller: state encoding,
// delay-slot select codes and the debug state width.
package alarm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ARMED      = 3'd0,
        TRIGGERED  = 3'd1,
        SOUND      = 3'd2,
        HOLD       = 3'd3,
        DISARMED   = 3'd4,
        WAIT_OPEN  = 3'd5,
        WAIT_CLOSE = 3'd6,
        ARM_DLY    = 3'd7
    } state_t;

    localparam logic [1:0] SEL_ARM = 2'd0;
    localparam logic [1:0] SEL_DRV = 2'd1;
    localparam logic [1:0] SEL_PAS = 2'd2;
    localparam logic [1:0] SEL_ALM = 2'd3;

    // States whose exit depends on the countdown timer
    function automatic logic is_timed(input state_t s);
        return (s == TRIGGERED) || (s == HOLD) || (s == ARM_DLY);
    endfunction

endpackage

// File: rtl/alarm_timer.sv
// Countdown timer: a TICK_DIV prescaler feeding a CNT_W tick counter.
// A load of N raises expire for one cycle N*TICK_DIV cycles later (N=0: next
// cycle). clear abandons a running countdown. The prescaler free-runs when
// idle and its wrap is exported as tick; load and expire both restart it so
// the tick phase is aligned to the start of the state that follows.
module alarm_timer #(
    parameter int CNT_W    = 4,
    parameter int TICK_DIV = 27000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [CNT_W-1:0] value,
    output logic             expire,
    output logic             tick
);

    localparam int               PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] cnt;
    logic             active;

    assign tick   = (pre == '0);
    assign expire = active && ((cnt == '0) || ((cnt == CNT_W'(1)) && tick));

    // Prescaler, tick counter and running flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre    <= PRE_MAX;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            pre    <= PRE_MAX;
            cnt    <= value;
            active <= 1'b1;
        end else if (expire) begin
            pre    <= PRE_MAX;
            active <= 1'b0;
        end else begin
            pre <= tick ? PRE_MAX : pre - PRE_W'(1);
            if (clear) begin
                active <= 1'b0;
            end else if (active && tick) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alarm_fsm_multi.sv
// Vehicle anti-theft controller with N door sensors, an internal tick timer
// and run-time programmable delays (prog/time_sel/time_value).
// Build option: define FUEL_PUMP_LOCK_EN to require hidden & brakepedal
// while disarmed before the fuel pump is enabled.
module alarm_fsm_multi
    import alarm_pkg::*;
#(
    parameter int NUM_DOORS  = 4,
    parameter int DRIVER_IDX = 0,
    parameter int CNT_W      = 4,
    parameter int TICK_DIV   = 27000000,
    parameter int T_ARM_DEF  = 6,
    parameter int T_DRV_DEF  = 8,
    parameter int T_PAS_DEF  = 15,
    parameter int T_ALM_DEF  = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_DOORS-1:0] doors,
    input  logic                 ignition,
    input  logic                 hidden,
    input  logic                 brakepedal,
    input  logic                 prog,
    input  logic [1:0]           time_sel,
    input  logic [CNT_W-1:0]     time_value,
    output logic                 fuelpump,
    output logic                 status,
    output logic                 siren,
    output logic [STATE_W-1:0]   state_o
);

    localparam logic [NUM_DOORS-1:0] DRV_MASK = NUM_DOORS'(1) << DRIVER_IDX;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] t_arm, t_drv, t_pas, t_alm;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_clear;
    logic             tmr_expire;
    logic             tmr_tick;
    logic             driver_open;
    logic             other_open;
    logic             any_open;

    assign driver_open = doors[DRIVER_IDX];
    assign other_open  = |(doors & ~DRV_MASK);
    assign any_open    = |doors;
    assign tmr_clear   = !is_timed(state);
    assign state_o     = state;

`ifndef FUEL_PUMP_LOCK_EN
    logic unused_lock_inputs;
    assign unused_lock_inputs = hidden ^ brakepedal;
`endif

    // Programmable delay slots; a load in the same cycle still sees the old value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            t_arm <= CNT_W'(T_ARM_DEF);
            t_drv <= CNT_W'(T_DRV_DEF);
            t_pas <= CNT_W'(T_PAS_DEF);
            t_alm <= CNT_W'(T_ALM_DEF);
        end else if (prog) begin
            case (time_sel)
                SEL_ARM: t_arm <= time_value;
                SEL_DRV: t_drv <= time_value;
                SEL_PAS: t_pas <= time_value;
                SEL_ALM: t_alm <= time_value;
                default: ;
            endcase
        end
    end

    // Next-state decision and the timer load that accompanies entry to a timed state
    always_comb begin
        nxt       = state;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            ARMED: begin
                if (ignition) begin
                    nxt = DISARMED;
                end else if (driver_open) begin
                    nxt       = TRIGGERED;
                    tmr_load  = 1'b1;
                    tmr_value = t_drv;
                end else if (other_open) begin
                    nxt       = TRIGGERED;
                    tmr_load  = 1'b1;
                    tmr_value = t_pas;
                end
            end
            TRIGGERED: begin
                if (ignition)        nxt = DISARMED;
                else if (tmr_expire) nxt = SOUND;
            end
            SOUND: begin
                if (ignition) begin
                    nxt = DISARMED;
                end else if (!any_open) begin
                    nxt       = HOLD;
                    tmr_load  = 1'b1;
                    tmr_value = t_alm;
                end
            end
            HOLD: begin
                if (ignition)        nxt = DISARMED;
                else if (any_open)   nxt = SOUND;
                else if (tmr_expire) nxt = ARMED;
            end
            DISARMED: begin
                if (!ignition) nxt = WAIT_OPEN;
            end
            WAIT_OPEN: begin
                if (ignition)         nxt = DISARMED;
                else if (driver_open) nxt = WAIT_CLOSE;
            end
            WAIT_CLOSE: begin
                if (ignition) begin
                    nxt = DISARMED;
                end else if (!driver_open) begin
                    nxt       = ARM_DLY;
                    tmr_load  = 1'b1;
                    tmr_value = t_arm;
                end
            end
            ARM_DLY: begin
                if (ignition)         nxt = DISARMED;
                else if (driver_open) nxt = WAIT_CLOSE;
                else if (tmr_expire)  nxt = ARMED;
            end
            default: nxt = ARMED;
        endcase
    end

    alarm_timer #(
        .CNT_W    (CNT_W),
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (tmr_load),
        .clear  (tmr_clear),
        .value  (tmr_value),
        .expire (tmr_expire),
        .tick   (tmr_tick)
    );

    // State register with outputs registered from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ARMED;
            siren    <= 1'b0;
            status   <= 1'b0;
            fuelpump <= 1'b0;
        end else begin
            state <= nxt;
            siren <= (nxt == SOUND) || (nxt == HOLD);
            case (nxt)
                ARMED:                  status <= (state == ARMED) ? (status ^ tmr_tick) : 1'b0;
                TRIGGERED, SOUND, HOLD: status <= 1'b1;
                default:                status <= 1'b0;
            endcase
`ifdef FUEL_PUMP_LOCK_EN
            fuelpump <= (nxt == DISARMED) &&
                        (fuelpump || ((state == DISARMED) && hidden && brakepedal));
`else
            fuelpump <= (nxt == DISARMED) && ignition;
`endif
        end
    end

endmodule
